// File: rtl/pll_sweep_ctrl.sv
// rtl/pll_sweep_ctrl.sv - PLL frequency sweep controller with reconfig sequencing and elapsed counters
//
// Selects one of NUM_STEPS pll_reconfig ROM images, either manually (up/down
// buttons) or by an auto-sweep that steps toward slower settings while the
// tester reports failures. Each selection change runs the pll_reconfig
// handshake (load ROM image, settle, start reconfig, wait for busy to fall)
// and retries on timeout. Also keeps BCD-minute and tenths-of-second counters
// that measure time since the last reconfiguration.
//
// Ports:
//   clock_50_i          system clock
//   reset               synchronous active-high reset
//   btn_up/btn_down     debounced levels; rising edge steps pos -1 / +1
//   btn_auto            debounced level; rising edge toggles auto-sweep
//   auto_start          level; forces pos 0 with auto-sweep on
//   fail_seen           tester saw failures at the current pos
//   rcfg_busy           pll_reconfig busy
//   rcfg_write_from_rom 1-cycle pulse: load ROM image selected by pos
//   rcfg_reconfig       1-cycle pulse: start reconfiguration
//   rcfg_reset          1-cycle pulse: reset pll_reconfig after a timeout
//   pos                 current step, also the ROM mux select
//   auto_o              auto-sweep active
//   recfg_active        request pending or in progress
//   cfg_err             sticky: MAX_RETRY timeouts on one request
//   retry_cnt           timeouts seen on the current request
//   mins                4-digit BCD minutes since last reconfig
//   secs                binary 0.1 s count since last reconfig

module pll_sweep_ctrl #(
    parameter int NUM_STEPS   = 11,
    parameter int POS_W       = 4,
    parameter int DEFAULT_POS = 7,
    parameter int TIMEOUT_CYC = 1000,
    parameter int MAX_RETRY   = 3,
    parameter int SUBSEC_CYC  = 5000000,
    parameter int MIN_TICKS   = 600
) (
    input  logic             clock_50_i,
    input  logic             reset,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_auto,
    input  logic             auto_start,
    input  logic             fail_seen,
    input  logic             rcfg_busy,
    output logic             rcfg_write_from_rom,
    output logic             rcfg_reconfig,
    output logic             rcfg_reset,
    output logic [POS_W-1:0] pos,
    output logic             auto_o,
    output logic             recfg_active,
    output logic             cfg_err,
    output logic [1:0]       retry_cnt,
    output logic [15:0]      mins,
    output logic [15:0]      secs
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int SUB_W = $clog2(SUBSEC_CYC + 1);
    localparam int MIN_W = $clog2(MIN_TICKS + 1);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(NUM_STEPS - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_ISSUE, S_WAIT} state_t;

    state_t             state, state_nx;
    logic [TMO_W-1:0]   tmo, tmo_nx;
    logic [POS_W-1:0]   pos_nx;
    logic               auto_nx, err_nx;
    logic [1:0]         retry_nx;
    logic [2:0]         retry_inc;
    logic               up_q, down_q, auto_q;
    logic               up_ok, down_ok, auto_e;
    logic [SUB_W-1:0]   sub_cnt;
    logic [MIN_W-1:0]   min_cnt;

    // Button steps at a range limit are not requests at all, so they neither
    // start a sequence nor block a lower-priority request.
    assign auto_e  = btn_auto & ~auto_q;
    assign down_ok = btn_down & ~down_q & (pos < POS_MAX);
    assign up_ok   = btn_up & ~up_q & (pos != '0);
    assign retry_inc    = {1'b0, retry_cnt} + 3'd1;
    assign recfg_active = (state != S_IDLE);

    always_comb begin
        state_nx            = state;
        tmo_nx              = tmo;
        pos_nx              = pos;
        auto_nx             = auto_o;
        err_nx              = cfg_err;
        retry_nx            = retry_cnt;
        rcfg_write_from_rom = 1'b0;
        rcfg_reconfig       = 1'b0;
        rcfg_reset          = 1'b0;
        case (state)
            S_IDLE: begin
                if (auto_start) begin
                    pos_nx   = '0;
                    auto_nx  = 1'b1;
                    state_nx = S_LOAD;
                end else if (auto_e) begin
                    // Leaving auto re-applies the current pos; entering it restarts from the fastest step.
                    if (auto_o) begin
                        auto_nx = 1'b0;
                    end else begin
                        auto_nx = 1'b1;
                        pos_nx  = '0;
                    end
                    state_nx = S_LOAD;
                end else if (down_ok) begin
                    pos_nx   = pos + POS_W'(1);
                    auto_nx  = 1'b0;
                    state_nx = S_LOAD;
                end else if (up_ok) begin
                    pos_nx   = pos - POS_W'(1);
                    auto_nx  = 1'b0;
                    state_nx = S_LOAD;
                end else if (auto_o && fail_seen && (pos < POS_MAX)) begin
                    pos_nx   = pos + POS_W'(1);
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                rcfg_write_from_rom = 1'b1;
                state_nx            = S_SETTLE;
            end
            S_SETTLE: begin
                state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                if (!rcfg_busy) begin
                    rcfg_reconfig = 1'b1;
                    tmo_nx        = TMO_LOAD;
                    state_nx      = S_WAIT;
                end
            end
            S_WAIT: begin
                tmo_nx = tmo - TMO_W'(1);
                // pll_reconfig raises busy one cycle late, so the first WAIT cycle ignores it.
                if ((tmo != TMO_LOAD) && !rcfg_busy) begin
                    retry_nx = 2'd0;
                    state_nx = S_IDLE;
                end else if (tmo == TMO_W'(1)) begin
                    rcfg_reset = 1'b1;
                    if (retry_inc < 3'(MAX_RETRY)) begin
                        retry_nx = retry_inc[1:0];
                        state_nx = S_LOAD;
                    end else begin
                        err_nx   = 1'b1;
                        retry_nx = 2'd0;
                        state_nx = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
        // A reset cycle must never leak a handshake pulse.
        if (reset) begin
            rcfg_write_from_rom = 1'b0;
            rcfg_reconfig       = 1'b0;
            rcfg_reset          = 1'b0;
        end
    end

    always_ff @(posedge clock_50_i) begin
        if (reset) begin
            state     <= S_IDLE;
            tmo       <= '0;
            pos       <= POS_W'(DEFAULT_POS);
            auto_o    <= 1'b0;
            cfg_err   <= 1'b0;
            retry_cnt <= 2'd0;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            auto_q    <= 1'b0;
        end else begin
            state     <= state_nx;
            tmo       <= tmo_nx;
            pos       <= pos_nx;
            auto_o    <= auto_nx;
            cfg_err   <= err_nx;
            retry_cnt <= retry_nx;
            up_q      <= btn_up;
            down_q    <= btn_down;
            auto_q    <= btn_auto;
        end
    end

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Elapsed time restarts after every reconfiguration.
    always_ff @(posedge clock_50_i) begin
        if (reset || recfg_active) begin
            sub_cnt <= '0;
            min_cnt <= '0;
            secs    <= 16'd0;
            mins    <= 16'd0;
        end else if (sub_cnt == SUB_W'(SUBSEC_CYC - 1)) begin
            sub_cnt <= '0;
            secs    <= secs + 16'd1;
            if (min_cnt == MIN_W'(MIN_TICKS - 1)) begin
                min_cnt <= '0;
                mins    <= bcd_inc(mins);
            end else begin
                min_cnt <= min_cnt + MIN_W'(1);
            end
        end else begin
            sub_cnt <= sub_cnt + SUB_W'(1);
        end
    end

endmodule

// File: tb/tb_pll_sweep_ctrl.sv
// tb/tb_pll_sweep_ctrl.sv - self-checking bench for pll_sweep_ctrl

module tb_pll_sweep_ctrl;

    localparam int TMO  = 16;
    localparam int MAXR = 3;
    localparam int SUBC = 2;
    localparam int MINT = 2;
    localparam int PMAX = 10;

    logic        clock_50_i = 1'b0;
    logic        reset = 1'b1;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_auto = 1'b0;
    logic        auto_start = 1'b0, fail_seen = 1'b0, rcfg_busy = 1'b0;
    logic        rcfg_write_from_rom, rcfg_reconfig, rcfg_reset;
    logic [3:0]  pos;
    logic        auto_o, recfg_active, cfg_err;
    logic [1:0]  retry_cnt;
    logic [15:0] mins, secs;

    pll_sweep_ctrl #(
        .NUM_STEPS(11), .POS_W(4), .DEFAULT_POS(7), .TIMEOUT_CYC(TMO),
        .MAX_RETRY(MAXR), .SUBSEC_CYC(SUBC), .MIN_TICKS(MINT)
    ) dut (
        .clock_50_i(clock_50_i), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
        .btn_auto(btn_auto), .auto_start(auto_start), .fail_seen(fail_seen),
        .rcfg_busy(rcfg_busy), .rcfg_write_from_rom(rcfg_write_from_rom),
        .rcfg_reconfig(rcfg_reconfig), .rcfg_reset(rcfg_reset), .pos(pos),
        .auto_o(auto_o), .recfg_active(recfg_active), .cfg_err(cfg_err),
        .retry_cnt(retry_cnt), .mins(mins), .secs(secs)
    );

    always #5 clock_50_i = ~clock_50_i;

    int n_chk = 0, n_fail = 0;

    // Behavioural model: request timeline measured in cycles since acceptance.
    int m_pos = 7, m_retry = 0, m_age = 0, m_issue = 0, m_elapsed = 0;
    bit m_auto = 0, m_err = 0, m_issued = 0, pu = 0, pd = 0, pa = 0;
    // pll_reconfig stand-in
    int busy_left = 0, busy_len = 0;
    bit busy_extra = 0;
    // event tracking
    int cyc = 0, last_wr = -1, last_rc = -1, last_rr = -1, last_act = -1, n_wr = 0, n_rr = 0;

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
            if (n_fail >= 40) summary();
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic cycle();
        bit ewr, erc, err_p, busy_v, ue, de, ae, acc;
        int w;
        @(negedge clock_50_i);
        busy_v = (busy_left > 0) || busy_extra;
        rcfg_busy = busy_v;
        #1;
        w = m_age - m_issue;
        ewr = 0; erc = 0; err_p = 0;
        if (!reset) begin
            if (m_age == 1) ewr = 1;
            else if (m_age >= 3 && !m_issued && !busy_v) erc = 1;
            else if (m_issued && w == TMO && busy_v) err_p = 1;
        end
        chk("write_from_rom", 32'(rcfg_write_from_rom), 32'(ewr));
        chk("reconfig", 32'(rcfg_reconfig), 32'(erc));
        chk("rcfg_reset", 32'(rcfg_reset), 32'(err_p));
        chk("pos", 32'(pos), 32'(m_pos));
        chk("auto_o", 32'(auto_o), 32'(m_auto));
        chk("recfg_active", 32'(recfg_active), 32'(m_age > 0));
        chk("cfg_err", 32'(cfg_err), 32'(m_err));
        chk("retry_cnt", 32'(retry_cnt), 32'(m_retry));
        chk("secs", 32'(secs), 32'((m_elapsed / SUBC) % 65536));
        chk("mins", 32'(mins), 32'(to_bcd((m_elapsed / (SUBC * MINT)) % 10000)));
        if (rcfg_write_from_rom) begin last_wr = cyc; n_wr++; end
        if (rcfg_reconfig) last_rc = cyc;
        if (rcfg_reset) begin last_rr = cyc; n_rr++; end
        if (recfg_active) last_act = cyc;
        if (reset) begin
            m_pos = 7; m_auto = 0; m_err = 0; m_retry = 0; m_age = 0; m_issued = 0;
            m_elapsed = 0; pu = 0; pd = 0; pa = 0; busy_left = 0;
        end else begin
            ue = btn_up && !pu; de = btn_down && !pd; ae = btn_auto && !pa;
            pu = btn_up; pd = btn_down; pa = btn_auto;
            if (m_age > 0) m_elapsed = 0; else m_elapsed++;
            if (m_age == 0) begin
                acc = 1;
                if (auto_start) begin m_pos = 0; m_auto = 1; end
                else if (ae) begin
                    if (m_auto) m_auto = 0; else begin m_auto = 1; m_pos = 0; end
                end
                else if (de && m_pos < PMAX) begin m_pos++; m_auto = 0; end
                else if (ue && m_pos > 0) begin m_pos--; m_auto = 0; end
                else if (m_auto && fail_seen && m_pos < PMAX) m_pos++;
                else acc = 0;
                if (acc) begin m_age = 1; m_issued = 0; end
            end else if (m_issued) begin
                if (w >= 2 && !busy_v) begin m_age = 0; m_retry = 0; end
                else if (w == TMO) begin
                    m_retry++;
                    if (m_retry >= MAXR) begin m_err = 1; m_retry = 0; m_age = 0; end
                    else begin m_age = 1; m_issued = 0; end
                end else m_age++;
            end else begin
                if (erc) begin m_issued = 1; m_issue = m_age; end
                m_age++;
            end
            if (erc) busy_left = busy_len;
            else if (err_p) busy_left = 0;
            else if (busy_left > 0) busy_left--;
        end
        cyc++;
        @(posedge clock_50_i);
        #1;
    endtask

    initial begin
        int acc, wr0, rr0;
        repeat (3) @(posedge clock_50_i);
        #1;
        reset = 1'b0;

        // reset state and first counter tick
        chk("rst_pos", 32'(pos), 32'd7);
        chk("rst_active", 32'(recfg_active), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);
        cycle(); cycle();
        chk("secs_first_tick", 32'(secs), 32'd1);

        // btn_up with a 5-cycle busy response
        busy_len = 5;
        acc = cyc; btn_up = 1; cycle(); btn_up = 0;
        repeat (15) cycle();
        chk("up_pos", 32'(pos), 32'd6);
        chk("up_wr_cycle", 32'(last_wr - acc), 32'd1);
        chk("up_rc_cycle", 32'(last_rc - acc), 32'd3);
        chk("up_active_end", 32'(last_act - acc), 32'd9);

        // busy stuck high: three timeouts then cfg_err
        busy_len = 1000; rr0 = n_rr;
        btn_down = 1; cycle(); btn_down = 0;
        repeat (80) cycle();
        chk("tmo_resets", 32'(n_rr - rr0), 32'd3);
        chk("tmo_spacing", 32'(last_rr - last_rc), 32'd16);
        chk("tmo_err", 32'(cfg_err), 32'd1);
        chk("tmo_idle", 32'(recfg_active), 32'd0);

        // auto sweep to the slowest step
        busy_len = 2; wr0 = n_wr;
        auto_start = 1; cycle(); auto_start = 0;
        fail_seen = 1;
        repeat (150) cycle();
        fail_seen = 0;
        chk("sweep_loads", 32'(n_wr - wr0), 32'd11);
        chk("sweep_pos", 32'(pos), 32'd10);
        chk("sweep_auto", 32'(auto_o), 32'd1);

        // limits and simultaneous edges
        wr0 = n_wr;
        btn_down = 1; repeat (5) cycle(); btn_down = 0; cycle();
        chk("down_limit_loads", 32'(n_wr - wr0), 32'd0);
        btn_up = 1; cycle(); btn_up = 0; repeat (10) cycle();
        chk("up_from_max", 32'(pos), 32'd9);
        chk("up_clears_auto", 32'(auto_o), 32'd0);
        btn_up = 1; btn_down = 1; cycle(); btn_up = 0; btn_down = 0; repeat (10) cycle();
        chk("both_edges", 32'(pos), 32'd10);

        // reset in WAIT
        busy_len = 1000;
        btn_up = 1; cycle(); btn_up = 0;
        repeat (8) cycle();
        reset = 1; cycle(); reset = 0;
        chk("midrst_pos", 32'(pos), 32'd7);
        chk("midrst_err", 32'(cfg_err), 32'd0);
        chk("midrst_active", 32'(recfg_active), 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) btn_up = ~btn_up;
            if ($urandom_range(0, 15) == 0) btn_down = ~btn_down;
            if ($urandom_range(0, 31) == 0) btn_auto = ~btn_auto;
            auto_start = ($urandom_range(0, 99) == 0);
            fail_seen  = ($urandom_range(0, 3) != 0);
            busy_extra = ($urandom_range(0, 7) == 0);
            busy_len   = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 20));
            reset      = ($urandom_range(0, 299) == 0);
            cycle();
        end

        // long idle run: BCD carries and the 9999 wrap
        btn_up = 0; btn_down = 0; btn_auto = 0; auto_start = 0; fail_seen = 0;
        busy_extra = 0; reset = 1; cycle(); reset = 0;
        for (int i = 0; i < 40010; i++) begin
            cycle();
            if (m_elapsed == 3839) chk("mins_0959", 32'(mins), 32'h0959);
            if (m_elapsed == 4000) chk("mins_1000", 32'(mins), 32'h1000);
            if (m_elapsed == 39999) chk("mins_9999", 32'(mins), 32'h9999);
            if (m_elapsed == 40000) chk("mins_wrap", 32'(mins), 32'h0000);
        end
        summary();
    end

endmodule
